// File: rtl/nms_window_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 NMS window generator.
interface nms_window_gen_if #(
    parameter int DATA_W = 64,
    parameter int XW     = 10,
    parameter int YW     = 9
);
    logic                  in_valid;
    logic                  in_sof;
    logic [DATA_W-1:0]     in_data;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   win_data;
    logic [XW-1:0]         win_x;
    logic [YW-1:0]         win_y;
    logic                  frame_done;

    modport mst (
        output in_valid, in_sof, in_data,
        input  win_valid, win_data, win_x, win_y, frame_done
    );
    modport slv (
        input  in_valid, in_sof, in_data,
        output win_valid, win_data, win_x, win_y, frame_done
    );
endinterface

// File: rtl/nms_window_gen.sv
// 3x3 window of Harris responses built from two line buffers and a shift array;
// one window per interior pixel, emitted one cycle after the pixel is accepted.
module nms_window_gen #(
    parameter int DATA_W = 64,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic              clk,
    input  logic              reset,
    nms_window_gen_if.slv     bus
);
    logic [XW-1:0]          cx_q, cx_d, px;
    logic [YW-1:0]          cy_q, cy_d, py;
    logic [DATA_W-1:0]      lb1_q [IMG_W];
    logic [DATA_W-1:0]      lb2_q [IMG_W];
    logic [DATA_W-1:0]      lb1_rd, lb2_rd;
    logic [DATA_W-1:0]      w_q [3][3];
    logic [DATA_W-1:0]      w_d [3][3];
    logic [9*DATA_W-1:0]    w_flat;
    logic                   last_px, interior;

    logic                   win_valid_q, frame_done_q;
    logic [9*DATA_W-1:0]    win_data_q;
    logic [XW-1:0]          win_x_q;
    logic [YW-1:0]          win_y_q;

    // in_sof relocates the incoming pixel to (0,0), discarding any partial frame
    assign px       = bus.in_sof ? '0 : cx_q;
    assign py       = bus.in_sof ? '0 : cy_q;
    assign lb1_rd   = lb1_q[px];
    assign lb2_rd   = lb2_q[px];
    assign last_px  = (px == XW'(IMG_W-1)) && (py == YW'(IMG_H-1));
    assign interior = (px >= XW'(2)) && (py >= YW'(2));

    always_comb begin
        cx_d = px + XW'(1);
        cy_d = py;
        if (px == XW'(IMG_W-1)) begin
            cx_d = '0;
            cy_d = (py == YW'(IMG_H-1)) ? '0 : py + YW'(1);
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_d[r][0] = w_q[r][1];
            w_d[r][1] = w_q[r][2];
        end
        w_d[0][2] = lb2_rd;
        w_d[1][2] = lb1_rd;
        w_d[2][2] = bus.in_data;
        w_flat    = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_flat[(r*3+c)*DATA_W +: DATA_W] = w_d[r][c];
    end

    // Line-buffer RAM is never cleared: rows 0/1 of every frame overwrite it before use
    always_ff @(posedge clk) begin
        if (!reset && bus.in_valid) begin
            lb2_q[px] <= lb1_rd;
            lb1_q[px] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q         <= '0;
            cy_q         <= '0;
            w_q          <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                cx_q         <= cx_d;
                cy_q         <= cy_d;
                w_q          <= w_d;
                frame_done_q <= last_px;
                if (interior) begin
                    win_valid_q <= 1'b1;
                    win_data_q  <= w_flat;
                    win_x_q     <= px - XW'(1);
                    win_y_q     <= py - YW'(1);
                end
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_x      = win_x_q;
    assign bus.win_y      = win_y_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_nms_window_gen.sv
// Scoreboard bench for nms_window_gen on a 5x4 frame; expected windows come from a 2-D image model.
module tb_nms_window_gen;
    localparam int DW = 64, IW = 5, IH = 4, XW = 3, YW = 2;

    typedef struct {
        logic [9*DW-1:0] data;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        int              cyc;
    } win_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nms_window_gen_if #(.DATA_W(DW), .XW(XW), .YW(YW)) bus();

    nms_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .XW(XW), .YW(YW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, failures = 0, cyc = 0;
    int win_cnt = 0, fd_cnt = 0;
    win_t wq[$];
    int   fq[$];
    logic [DW-1:0] img [IH][IW];
    int mx = 0, my = 0;
    logic [9*DW-1:0] w21;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        win_t w;
        int   fc;
        if (bus.win_valid === 1'b1) begin
            win_cnt++;
            if (bus.win_x == XW'(2) && bus.win_y == YW'(1)) w21 = bus.win_data;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window x=%0d y=%0d cyc=%0d", bus.win_x, bus.win_y, cyc);
            end else begin
                w = wq.pop_front();
                if (bus.win_data !== w.data) begin
                    failures++;
                    $display("FAIL win_data (%0d,%0d) got=%h exp=%h", w.x, w.y, bus.win_data, w.data);
                end
                checks++;
                if (bus.win_x !== w.x || bus.win_y !== w.y) begin
                    failures++;
                    $display("FAIL win_xy got=(%0d,%0d) exp=(%0d,%0d)", bus.win_x, bus.win_y, w.x, w.y);
                end
                checks++;
                if (cyc !== w.cyc) begin
                    failures++;
                    $display("FAIL win_latency (%0d,%0d) got_cyc=%0d exp_cyc=%0d", w.x, w.y, cyc, w.cyc);
                end
            end
        end
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame_done cyc=%0d", cyc);
            end else begin
                fc = fq.pop_front();
                if (cyc !== fc) begin
                    failures++;
                    $display("FAIL frame_done_cycle got=%0d exp=%0d", cyc, fc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
        end
    endtask

    task automatic drive_pix(input logic [DW-1:0] v, input logic sof);
        win_t w;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = v;
        if (sof) begin mx = 0; my = 0; end
        img[my][mx] = v;
        if (mx >= 2 && my >= 2) begin
            w.data = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w.data[(r*3+c)*DW +: DW] = img[my-2+r][mx-2+c];
            w.x   = XW'(mx - 1);
            w.y   = YW'(my - 1);
            w.cyc = cyc + 1;
            wq.push_back(w);
        end
        if (mx == IW-1 && my == IH-1) fq.push_back(cyc + 1);
        if (mx == IW-1) begin
            mx = 0;
            my = (my == IH-1) ? 0 : my + 1;
        end else mx++;
    endtask

    function automatic logic [DW-1:0] pix(input int x, input int y, input int off, input logic neg);
        longint s;
        s = neg ? -longint'(16*y + x) - 1 : longint'(16*y + x + off);
        return s;
    endfunction

    task automatic drive_frame(input int off, input logic neg, input int gap_pct, input logic sof_first);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
                while ($urandom_range(0, 99) < gap_pct) idle(1);
                drive_pix(pix(x, y, off, neg), sof_first && x == 0 && y == 0);
            end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags win_valid=%b frame_done=%b exp=0", bus.win_valid, bus.frame_done);
        end
        checks++;
        if (bus.win_data !== '0 || bus.win_x !== '0 || bus.win_y !== '0) begin
            failures++;
            $display("FAIL reset_outputs x=%0d y=%0d data_nonzero=%b exp=0", bus.win_x, bus.win_y, |bus.win_data);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_continuous;
        int s_w, s_f;
        logic [9*DW-1:0] e21;
        int e[9] = '{'h01, 'h02, 'h03, 'h11, 'h12, 'h13, 'h21, 'h22, 'h23};
        for (int k = 0; k < 9; k++) e21[k*DW +: DW] = DW'(e[k]);
        w21 = '0; s_w = win_cnt; s_f = fd_cnt;
        drive_frame(0, 1'b0, 0, 1'b0);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 6 || fd_cnt - s_f !== 1) begin
            failures++;
            $display("FAIL continuous_counts windows=%0d fd=%0d exp=6/1", win_cnt - s_w, fd_cnt - s_f);
        end
        checks++;
        if (w21 !== e21) begin
            failures++;
            $display("FAIL continuous_win21 got=%h exp=%h", w21, e21);
        end
        checks++;
        if (wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL continuous_drain left_win=%0d left_fd=%0d exp=0", wq.size(), fq.size());
        end
        wq.delete(); fq.delete();
    endtask

    task automatic test_gaps;
        int s_w;
        s_w = win_cnt;
        drive_frame(0, 1'b0, 40, 1'b0);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 6 || wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL gaps windows=%0d left_win=%0d left_fd=%0d exp=6/0/0", win_cnt - s_w, wq.size(), fq.size());
        end
        wq.delete(); fq.delete();
    endtask

    task automatic test_back_to_back;
        int s_w, s_f;
        s_w = win_cnt; s_f = fd_cnt;
        drive_frame(0, 1'b0, 0, 1'b0);
        drive_frame('h100, 1'b0, 0, 1'b0);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 12 || fd_cnt - s_f !== 2) begin
            failures++;
            $display("FAIL back_to_back windows=%0d fd=%0d exp=12/2", win_cnt - s_w, fd_cnt - s_f);
        end
        checks++;
        if (wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL back_to_back_drain left_win=%0d left_fd=%0d exp=0", wq.size(), fq.size());
        end
        wq.delete(); fq.delete();
    endtask

    task automatic test_sof_restart;
        int s_w, s_f;
        s_w = win_cnt; s_f = fd_cnt;
        for (int i = 0; i < 2*IW + 2; i++) drive_pix(pix(i % IW, i / IW, 'h40, 1'b0), 1'b0);
        drive_frame(0, 1'b0, 0, 1'b1);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 6 || fd_cnt - s_f !== 1) begin
            failures++;
            $display("FAIL sof_restart windows=%0d fd=%0d exp=6/1", win_cnt - s_w, fd_cnt - s_f);
        end
        checks++;
        if (wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL sof_restart_drain left_win=%0d left_fd=%0d exp=0", wq.size(), fq.size());
        end
        wq.delete(); fq.delete();
    endtask

    task automatic test_reset_mid;
        int s_w, s_f;
        for (int i = 0; i < 2*IW + 3; i++) drive_pix(pix(i % IW, i / IW, 'h80, 1'b0), 1'b0);
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pix(3, 2, 'h80, 1'b0);
        mx = 0; my = 0;
        @(negedge clk);
        checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_data !== '0 ||
            bus.win_x !== '0 || bus.win_y !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs win_valid=%b fd=%b x=%0d y=%0d exp=all0",
                     bus.win_valid, bus.frame_done, bus.win_x, bus.win_y);
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        wq.delete(); fq.delete();
        s_w = win_cnt; s_f = fd_cnt;
        drive_frame(0, 1'b0, 0, 1'b0);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 6 || fd_cnt - s_f !== 1 || wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_frame windows=%0d fd=%0d left=%0d exp=6/1/0",
                     win_cnt - s_w, fd_cnt - s_f, wq.size());
        end
        wq.delete(); fq.delete();
    endtask

    task automatic test_negative;
        int s_w;
        s_w = win_cnt;
        drive_frame(0, 1'b1, 20, 1'b0);
        idle(3);
        checks++;
        if (win_cnt - s_w !== 6 || wq.size() !== 0 || fq.size() !== 0) begin
            failures++;
            $display("FAIL negative windows=%0d left_win=%0d exp=6/0", win_cnt - s_w, wq.size());
        end
        wq.delete(); fq.delete();
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid();
        test_negative();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
